// File: rtl/usr_pkg.sv
// usr_pkg: shared encodings for the USR command sequencer and its environment.
package usr_pkg;
   localparam int USR_DATA_W = 4;
   localparam int USR_CNT_W = 3;
   localparam logic [1:0] USR_HOLD = 2'b00;
   localparam logic [1:0] USR_SHR = 2'b01;
   localparam logic [1:0] USR_SHL = 2'b10;
   localparam logic [1:0] USR_LOAD = 2'b11;
   typedef enum logic [1:0] {
      OP_CLR = 2'b00,
      OP_SHR = 2'b01,
      OP_SHL = 2'b10,
      OP_LOAD = 2'b11
   } op_e;
   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_CAPTURE,
      S_RESP
   } state_e;
endpackage

// File: rtl/usr_ctrl.sv
// usr_ctrl: sequences one clear/load/shift/read command onto the USR control pins
// and returns the resulting register value over a valid/ready response.
module usr_ctrl
   import usr_pkg::*;
#(
   parameter int DATA_W = USR_DATA_W,
   parameter int CNT_W = USR_CNT_W
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              usr_rst,
   output logic [1:0]        usr_mode,
   output logic [DATA_W-1:0] usr_data_in,
   input  logic [DATA_W-1:0] usr_data_out
);
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic usr_rst_q, usr_rst_d;
   logic [1:0] usr_mode_q, usr_mode_d;
   logic [DATA_W-1:0] usr_data_in_q, usr_data_in_d;
   logic rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   op_e op;
   assign op = op_e'(cmd_op);
   assign cmd_ready = state_q == S_IDLE;
   assign busy = state_q != S_IDLE;
   assign usr_rst = usr_rst_q;
   assign usr_mode = usr_mode_q;
   assign usr_data_in = usr_data_in_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data = rsp_data_q;
   // usr_rst defaults low so the USR leaves reset on the first edge after rst falls
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      usr_rst_d = 1'b0;
      usr_mode_d = usr_mode_q;
      usr_data_in_d = usr_data_in_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (op)
                  OP_CLR: begin
                     state_d = S_CLR;
                     usr_rst_d = 1'b1;
                  end
                  OP_LOAD: begin
                     state_d = S_RUN;
                     usr_mode_d = USR_LOAD;
                     usr_data_in_d = cmd_data;
                     cnt_d = CNT_W'(1);
                  end
                  default: begin
                     // fill replicated so the USR may sample any data_in bit
                     state_d = cmd_count == '0 ? S_CAPTURE : S_RUN;
                     usr_mode_d = cmd_count == '0 ? USR_HOLD : (op == OP_SHR ? USR_SHR : USR_SHL);
                     usr_data_in_d = cmd_count == '0 ? usr_data_in_q : {DATA_W{cmd_data[0]}};
                     cnt_d = cmd_count;
                  end
               endcase
            end
         end
         S_CLR: state_d = S_CAPTURE;
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               usr_mode_d = USR_HOLD;
               usr_data_in_d = '0;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            rsp_data_d = usr_data_out;
            rsp_valid_d = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         usr_rst_q <= 1'b1;
         usr_mode_q <= USR_HOLD;
         usr_data_in_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         usr_rst_q <= usr_rst_d;
         usr_mode_q <= usr_mode_d;
         usr_data_in_q <= usr_data_in_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q <= rsp_data_d;
      end
   end
endmodule

// File: doc/usr_ctrl.md
# usr_ctrl

Command sequencer for the 4-bit universal shift register (USR). Accepts one command at a time over a valid/ready handshake: clear, parallel load, multi-position shift right/left with a chosen fill bit, or read. Drives the USR's reset, mode and data inputs cycle by cycle, then returns the resulting register value over a second valid/ready handshake. Sits between a bus-side requester and the USR instance; it is the only driver of the USR control inputs.

## Interface
Parameters:
- DATA_W, 4, USR width
- CNT_W, 3, shift-count width (0..7 positions)

Ports:
- clock  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; high only in IDLE
- cmd_op  in  2  00 CLR, 01 SHR, 10 SHL, 11 LOAD
- cmd_data  in  DATA_W  LOAD: value; SHR/SHL: fill bit in cmd_data[0]; CLR: ignored
- cmd_count  in  CNT_W  SHR/SHL: positions; 0 = read without shifting; ignored for LOAD/CLR
- rsp_valid  out  1  result held on rsp_data
- rsp_ready  in  1  requester takes result
- rsp_data  out  DATA_W  USR data_out captured after the command
- busy  out  1  state != IDLE
- usr_rst  out  1  to USR rst
- usr_mode  out  2  to USR mode: 00 hold, 01 shift right, 10 shift left, 11 load
- usr_data_in  out  DATA_W  to USR data_in
- usr_data_out  in  DATA_W  from USR data_out

## Operation
- States: IDLE, CLR, RUN, CAPTURE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready edge: latch op/data/count.
  - CLR: -> CLR, usr_rst=1.
  - LOAD: -> RUN, usr_mode=11, usr_data_in=cmd_data, cnt=1.
  - SHR/SHL, count>0: -> RUN, usr_mode=01/10, usr_data_in={DATA_W{cmd_data[0]}} (fill bit replicated, so independent of which bit the USR samples), cnt=count.
  - SHR/SHL, count=0: -> CAPTURE, usr_mode stays 00.
- CLR: one cycle; next edge usr_rst=0, -> CAPTURE.
- RUN: each edge the USR executes usr_mode; cnt decrements; on edge where cnt goes 1->0: usr_mode=00, usr_data_in=0, -> CAPTURE.
- CAPTURE: next edge rsp_data<=usr_data_out, rsp_valid=1, -> RESP.
- RESP: hold rsp_valid and rsp_data stable; on rsp_valid&&rsp_ready edge rsp_valid=0, -> IDLE.
- Shift semantics: right moves toward bit 0, fill enters at MSB; left moves toward MSB, fill enters at bit 0.
- cmd_valid ignored outside IDLE; no queueing.

## Timing
- Reset values (asserted asynchronously): state IDLE, cmd_ready=1, usr_rst=1, usr_mode=00, usr_data_in=0, rsp_valid=0, rsp_data=0, busy=0, cnt=0. usr_rst deasserts on the first posedge after rst falls, so the USR always leaves reset cleared.
- All outputs except cmd_ready and busy are registered; cmd_ready/busy decode state only.
- Accept edge E0 -> usr_mode active for exactly N edges (E1..EN; N=1 LOAD/CLR, N=count shifts) -> capture at E(N+1) -> rsp_valid high from E(N+1). Count 0: capture at E1.
- Back-to-back: IDLE entered on the response handshake edge; next command accepted no earlier than the following edge (1-cycle bubble).
- rsp_ready held low: stays in RESP indefinitely, USR held (mode 00).
- rst mid-command: command dropped, no response, all outputs to reset values, USR cleared via usr_rst.

## Structure
- Package usr_pkg: mode encodings (USR_HOLD, USR_SHR, USR_SHL, USR_LOAD), command op enum, state enum, DATA_W/CNT_W defaults; shared with the USR testbench interface and agents.
- Single module; no sub-module. Bench instantiates usr_ctrl and the USR together and also checks usr_* pins directly.

## Test plan
- Reset: rst high mid-run -> usr_rst=1, usr_mode=00, rsp_valid=0, cmd_ready=1; first edge after release usr_rst=0, USR data_out=0000.
- LOAD 1011 -> usr_mode=11 for exactly 1 cycle, rsp_valid 2 cycles after accept, rsp_data=1011.
- USR=1000, SHR count=2 fill=1 -> two cycles of mode 01, rsp_data=1110, rsp_valid 3 cycles after accept.
- USR=0001, SHL count=7 fill=0 -> seven cycles of mode 10, rsp_data=0000; then SHR count=0 -> no mode pulse, rsp_data=0000 one cycle after capture.
- LOAD 0110, hold rsp_ready low 5 cycles while driving cmd_valid -> cmd_ready=0, rsp_data stays 0110, usr_mode=00 throughout; release -> IDLE, next command accepted one edge later.
- LOAD 1111 then CLR -> usr_rst high exactly one cycle, rsp_data=0000.
